// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Loads the instruction memory from an external byte stream and keeps the CPU
// held (PC at 0) until the image is complete. Stream format: one length byte
// N (0..DEPTH), then N big-endian 32-bit words. A single-cycle load_i pulse
// restarts the sequence from any state, so a new image can be loaded without
// a system reset.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   When defined, one trailing byte equal to the modulo-256 sum of all data
//   bytes is required after the last word (also when N == 0, where it must be
//   0x00). A mismatch aborts the load into the error state.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   load_i         single-cycle pulse, restarts the load sequence
//   byte_valid_i   source presents a byte on byte_data_i
//   byte_data_i    stream byte
//   byte_ready_o   loader accepts a byte this cycle
//   mem_we_o       instruction RAM write enable (one-cycle pulse)
//   mem_waddr_o    word address of the write (holds when mem_we_o = 0)
//   mem_wdata_o    write data (holds when mem_we_o = 0)
//   cpu_hold_o     1 holds the CPU
//   done_o         image loaded, CPU running
//   err_o          load aborted; sticky until the next load or reset
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          cpu_hold_o,
  output logic          done_o,
  output logic          err_o
);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_RUN, S_ERR, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_RUN, S_ERR} state_t;
`endif

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;     // one extra bit so N == DEPTH fits
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   idx_inc;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   word_q, word_d;   // first three bytes of the word in flight
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [7:0]    csum_q, csum_d;
  logic          xfer;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_LEN;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      csum_q  <= csum_d;
    end
  end

  assign idx_inc = idx_q + 1'b1;
  assign xfer    = byte_valid_i && byte_ready_o;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    csum_d  = csum_q;

    case (state_q)
      S_LEN: begin
        if (xfer) begin
          csum_d = '0;
          if (byte_data_i == 8'd0) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_RUN;
`endif
          end else if (byte_data_i > DEPTH_B) begin
            state_d = S_ERR;
          end else begin
            len_d   = byte_data_i[AW:0];
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          csum_d = csum_q + byte_data_i;
          if (cnt_q == 2'd3) begin
            // Address and data are captured here so they stay stable after
            // the write while idx_q moves on.
            waddr_d = idx_q[AW-1:0];
            wdata_d = {word_q, byte_data_i};
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            word_d = {word_q[15:0], byte_data_i};
            cnt_d  = cnt_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == len_q) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_RUN;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (byte_data_i == csum_q) ? S_RUN : S_ERR;
      end
`endif
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_LEN;
    endcase

    // Load overrides everything decided above, including a byte accepted in
    // the same cycle. A write already in S_WRITE still goes out because
    // mem_we_o is decoded from the current state.
    if (load_i) begin
      state_d = S_LEN;
      idx_d   = '0;
      cnt_d   = '0;
      word_d  = '0;
      csum_d  = '0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
  assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA);
`endif
  assign mem_we_o    = (state_q == S_WRITE);
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_hold_o  = (state_q != S_RUN);
  assign done_o      = (state_q == S_RUN);
  assign err_o       = (state_q == S_ERR);

endmodule
